// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-precision ALU sequencer.
// Contents: ALU word width, operation encodings, FSM state encodings and
// a small helper that classifies an operation as add-type or sub-type.
package alu_seq_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDC = 2'b01,
    OP_SUB  = 2'b10,
    OP_SUBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit 1 of the opcode selects subtraction for both plain and chained forms.
  function automatic logic op_is_sub(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_mp_sequencer.sv
// Multi-word arithmetic controller for an external combinational 16-bit
// ALU_CC. Wide operands are latched on start and walked least-significant
// word first, one word per cycle, chaining the carry/borrow through alu_pre_c.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, op, n_words     request, opcode (ADD/ADDC/SUB/SUBB), word count
//   op_a, op_b             wide operands, word i at [W*i +: W]
//   busy, done             busy while walking words, one-cycle done pulse
//   result                 wide result, words beyond the count are zero
//   cc_z/v/c/n             persistent condition codes (cc_c feeds ADDC/SUBB)
//   alu_a/b, alu_pre_c,
//   alu_adc/sub/sbb        operand words and controls to ALU_CC
//   alu_y, alu_z/v/c/n     ALU_CC result word and flags
//   dbg_state              current FSM state
//
// Handshake: start is a level sampled only in IDLE; an accepted request
// raises busy from the next cycle, and done pulses for one cycle when
// result and cc_* are valid. Requests seen in RUN or DONE are dropped.
module alu_mp_sequencer #(
  parameter int W         = 16,
  parameter int MAX_WORDS = 4,
  parameter int NW_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [NW_W-1:0]        n_words,
  input  logic [W*MAX_WORDS-1:0] op_a,
  input  logic [W*MAX_WORDS-1:0] op_b,
  output logic                   busy,
  output logic                   done,
  output logic [W*MAX_WORDS-1:0] result,
  output logic                   cc_z,
  output logic                   cc_v,
  output logic                   cc_c,
  output logic                   cc_n,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic                   alu_pre_c,
  output logic                   alu_adc,
  output logic                   alu_sub,
  output logic                   alu_sbb,
  input  logic [W-1:0]           alu_y,
  input  logic                   alu_z,
  input  logic                   alu_v,
  input  logic                   alu_c,
  input  logic                   alu_n,
  output alu_seq_pkg::state_e    dbg_state
);
  import alu_seq_pkg::*;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [NW_W-1:0]        last_q, last_d;
  logic [NW_W-1:0]        idx_q, idx_d;
  logic [W*MAX_WORDS-1:0] a_q, a_d, b_q, b_d;
  logic [W*MAX_WORDS-1:0] res_q, res_d;
  logic                   zacc_q, zacc_d;
  logic                   carry_q, carry_d;
  logic                   cc_z_q, cc_z_d, cc_v_q, cc_v_d;
  logic                   cc_c_q, cc_c_d, cc_n_q, cc_n_d;

  logic [NW_W-1:0]        eff_n;
  logic [W-1:0]           word_a, word_b;
  logic                   first_word;

  // Word count 0 behaves as 1; anything above MAX_WORDS is clamped.
  always_comb begin
    if (n_words == '0)
      eff_n = NW_W'(1);
    else if (n_words > NW_W'(MAX_WORDS))
      eff_n = NW_W'(MAX_WORDS);
    else
      eff_n = n_words;
  end

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (idx_q == NW_W'(i)) begin
        word_a = a_q[W*i +: W];
        word_b = b_q[W*i +: W];
      end
    end
  end

  assign first_word = (idx_q == '0);

  // ALU drive: zero outside RUN. The first word takes its carry-in from
  // the condition codes (chained ops) or zero; later words take the carry
  // registered from the previous word, whatever borrow sense the ALU uses.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_pre_c = 1'b0;
    alu_adc   = 1'b0;
    alu_sub   = 1'b0;
    alu_sbb   = 1'b0;
    if (state_q == ST_RUN) begin
      alu_a = word_a;
      alu_b = word_b;
      if (first_word) begin
        case (op_q)
          OP_ADD:  ;
          OP_ADDC: begin alu_adc = 1'b1; alu_pre_c = cc_c_q; end
          OP_SUB:  alu_sub = 1'b1;
          OP_SUBB: begin alu_sbb = 1'b1; alu_pre_c = cc_c_q; end
          default: ;
        endcase
      end else begin
        alu_pre_c = carry_q;
        if (op_is_sub(op_q)) alu_sbb = 1'b1;
        else                 alu_adc = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    last_d  = last_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zacc_d  = zacc_q;
    carry_d = carry_q;
    cc_z_d  = cc_z_q;
    cc_v_d  = cc_v_q;
    cc_c_d  = cc_c_q;
    cc_n_d  = cc_n_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          last_d  = eff_n - NW_W'(1);
          a_d     = op_a;
          b_d     = op_b;
          res_d   = '0;
          idx_d   = '0;
          zacc_d  = 1'b1;
          carry_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < MAX_WORDS; i++) begin
          if (idx_q == NW_W'(i)) res_d[W*i +: W] = alu_y;
        end
        zacc_d  = zacc_q & alu_z;
        carry_d = alu_c;
        if (idx_q == last_q) begin
          cc_z_d  = zacc_q & alu_z;
          cc_v_d  = alu_v;
          cc_c_d  = alu_c;
          cc_n_d  = alu_n;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + NW_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      last_q  <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zacc_q  <= 1'b0;
      carry_q <= 1'b0;
      cc_z_q  <= 1'b0;
      cc_v_q  <= 1'b0;
      cc_c_q  <= 1'b0;
      cc_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zacc_q  <= zacc_d;
      carry_q <= carry_d;
      cc_z_q  <= cc_z_d;
      cc_v_q  <= cc_v_d;
      cc_c_q  <= cc_c_d;
      cc_n_q  <= cc_n_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = res_q;
  assign cc_z      = cc_z_q;
  assign cc_v      = cc_v_q;
  assign cc_c      = cc_c_q;
  assign cc_n      = cc_n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer. Includes a behavioural ALU_CC (carry flag is
// the borrow on subtraction) and a whole-width arithmetic reference model.
module tb_alu_mp_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [2:0]  n_words;
  logic [63:0] op_a, op_b;
  logic        busy, done;
  logic [63:0] result;
  logic        cc_z, cc_v, cc_c, cc_n;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_pre_c, alu_adc, alu_sub, alu_sbb;
  logic        alu_z, alu_v, alu_c, alu_n;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference condition codes, persisting between operations.
  logic m_cc_c;

  // Controls seen by the ALU on each RUN cycle of the last operation.
  logic rec_adc[8], rec_sub[8], rec_sbb[8], rec_pre_c[8];

  alu_mp_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .n_words(n_words),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .cc_z(cc_z), .cc_v(cc_v), .cc_c(cc_c), .cc_n(cc_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pre_c(alu_pre_c), .alu_adc(alu_adc),
    .alu_sub(alu_sub), .alu_sbb(alu_sbb), .alu_y(alu_y),
    .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU_CC environment model ----------------
  always_comb begin
    logic [16:0] t;
    logic        is_s;
    is_s = alu_sub | alu_sbb;
    if (is_s)
      t = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_sbb & alu_pre_c};
    else
      t = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_adc & alu_pre_c};
    alu_y = t[15:0];
    alu_c = t[16];
    alu_z = (t[15:0] == 16'd0);
    alu_n = t[15];
    if (is_s) alu_v = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
    else      alu_v = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
  end

  // ---------------- reference model ----------------
  function automatic int eff_words(input logic [2:0] nw);
    if (nw == 3'd0) return 1;
    if (nw > 3'd4)  return 4;
    return int'(nw);
  endfunction

  function automatic void ref_op(input logic [1:0] opc, input int n,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic cc_c_in,
                                 output logic [63:0] r, output logic z,
                                 output logic v, output logic c,
                                 output logic nf);
    logic [64:0] mask, full, am, bm;
    int          bits;
    logic        cin, sa, sb, sr;
    bits = 16 * n;
    mask = (65'd1 << bits) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    cin  = opc[0] ? cc_c_in : 1'b0;
    if (opc[1]) full = am - bm - {64'd0, cin};
    else        full = am + bm + {64'd0, cin};
    c  = full[bits];
    r  = 64'(full & mask);
    z  = (r == 64'd0);
    sa = a[bits-1];
    sb = b[bits-1];
    sr = r[bits-1];
    nf = sr;
    if (opc[1]) v = (sa != sb) && (sr != sa);
    else        v = (sa == sb) && (sr != sa);
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_alu_quiet(input string tag);
    check(tag, {30'd0, alu_a, alu_b, alu_pre_c, alu_adc, alu_sub, alu_sbb},
          64'd0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Returns at the negedge of the
  // cycle following done, so the next call starts back-to-back.
  task automatic run_op(input logic [1:0] opc, input logic [2:0] nw,
                        input logic [63:0] a, input logic [63:0] b,
                        input bit hold_start, input string tag);
    int          n, lat, busy_cnt, extra_done;
    logic [63:0] e_r;
    logic        e_z, e_v, e_c, e_n;
    n = eff_words(nw);
    ref_op(opc, n, a, b, m_cc_c, e_r, e_z, e_v, e_c, e_n);
    for (int i = 0; i < 8; i++) begin
      rec_adc[i] = 1'b0; rec_sub[i] = 1'b0;
      rec_sbb[i] = 1'b0; rec_pre_c[i] = 1'b0;
    end
    op = opc; n_words = nw; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      // Scramble inputs: the DUT must work from its latched copies.
      op_a    = {$urandom, $urandom};
      op_b    = {$urandom, $urandom};
      op      = 2'($urandom_range(0, 3));
      n_words = 3'($urandom_range(0, 7));
      start   = hold_start && (k <= n);
      if (k < 8) begin
        rec_adc[k] = alu_adc; rec_sub[k] = alu_sub;
        rec_sbb[k] = alu_sbb; rec_pre_c[k] = alu_pre_c;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(n + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    check({tag, "_result"}, result, e_r);
    check({tag, "_cc"}, {60'd0, cc_z, cc_v, cc_c, cc_n},
          {60'd0, e_z, e_v, e_c, e_n});
    check_alu_quiet({tag, "_alu_in_done"});
    m_cc_c = e_c;
    @(negedge clk);
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    if (hold_start) begin
      extra_done = 0;
      for (int k = 0; k < 2 * n; k++) begin
        @(negedge clk);
        if (done || busy) extra_done++;
      end
      check({tag, "_no_extra_done"}, 64'(extra_done), 64'd0);
      check({tag, "_result_held"}, result, e_r);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; n_words = 3'd0;
    op_a = 64'd0; op_b = 64'd0; m_cc_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {58'd0, busy, done, cc_z, cc_v, cc_c, cc_n}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    check_alu_quiet("reset_alu");
    rst = 1'b0;
    @(negedge clk);

    // Carry across the word boundary.
    run_op(OP_ADD, 3'd2, 64'h0001_FFFF, 64'h0000_0001, 1'b0, "add2");
    check("add2_value", result, 64'h0000_0000_0002_0000);
    check("add2_ctrl_w1", {62'd0, rec_adc[2], rec_pre_c[2]}, 64'd3);

    // Equal operands subtract to zero across two words.
    run_op(OP_SUB, 3'd2, 64'h1234_1234, 64'h1234_1234, 1'b0, "sub_eq");
    check("sub_eq_z", {63'd0, cc_z}, 64'd1);
    check("sub_eq_ctrl_w0", {62'd0, rec_sub[1], rec_sbb[1]}, 64'd2);
    check("sub_eq_ctrl_w1", {62'd0, rec_sub[2], rec_sbb[2]}, 64'd1);

    // Borrow across the word boundary, then a negative single-word result.
    run_op(OP_SUB, 3'd2, 64'h0001_0000, 64'h0000_0001, 1'b0, "sub_borrow");
    check("sub_borrow_value", result, 64'h0000_0000_0000_FFFF);
    run_op(OP_SUB, 3'd1, 64'h1234, 64'h2345, 1'b0, "sub_neg");
    check("sub_neg_value", result, 64'h0000_0000_0000_EEEF);
    check("sub_neg_n", {63'd0, cc_n}, 64'd1);

    // Preset cc_c then use it as carry-in.
    run_op(OP_ADD, 3'd1, 64'hFFFF, 64'h0001, 1'b0, "add_ovf");
    check("add_ovf_cz", {62'd0, cc_c, cc_z}, 64'd3);
    run_op(OP_ADDC, 3'd1, 64'h1234, 64'h2345, 1'b0, "addc");
    check("addc_value", result, 64'h0000_0000_0000_357A);
    check("addc_pre_c_w0", {62'd0, rec_adc[1], rec_pre_c[1]}, 64'd3);

    // Word count boundaries.
    run_op(OP_ADD, 3'd0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0,
           "nw0");
    run_op(OP_ADD, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "nw7");
    check("nw7_value", result, 64'd0);
    check("nw7_cz", {62'd0, cc_c, cc_z}, 64'd3);

    // start held high while busy.
    run_op(OP_SUBB, 3'd3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1,
           "start_busy");

    // Reset in the middle of a four-word operation.
    op = OP_ADD; n_words = 3'd4; op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom}; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {58'd0, busy, done, cc_z, cc_v, cc_c, cc_n},
          64'd0);
    check("midrst_result", result, 64'd0);
    check_alu_quiet("midrst_alu");
    m_cc_c = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Randomized back-to-back operations.
    for (int t = 0; t < 40; t++) begin
      run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, {$urandom, $urandom},
             bit'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
